// File: rtl/dram_sim_lat.sv
// rtl/dram_sim_lat.sv - behavioural single-outstanding DRAM model with per-op latency
// Optional protocol checking is built when DRAM_SIM_CHECK_EN is defined.
module dram_sim_lat #(
  parameter int MEM_BYTES  = 2**20,
  parameter int LINE_WORDS = 4,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                    w_mig_clk,
  input  logic                    w_mig_rst_n,
  output logic                    w_CLK,
  output logic                    w_o_rst_n,
  input  logic                    w_i_rd_en,
  input  logic                    w_i_wr_en,
  input  logic [31:0]             w_i_addr,
  input  logic [31:0]             w_i_data,
  input  logic [3:0]              w_i_mask,
  output logic [32*LINE_WORDS-1:0] w_o_data,
  output logic                    w_o_rvalid,
  output logic                    w_o_busy,
  output logic                    w_o_err
);

  localparam int AW  = $clog2(MEM_BYTES);
  localparam int WAW = AW - 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  logic [1:0]     state;
  logic [7:0]     cnt;
  logic [WAW-1:0] rd_base;
  logic [WAW-1:0] wr_idx;
  logic [31:0]    wr_data;
  logic [3:0]     wr_mask;
  logic [31:0]    mem [0:(MEM_BYTES/4)-1];

  logic [WAW-1:0] word_addr;
  logic [WAW-1:0] line_base;
  logic           done;
  logic           unused_bits;

  assign w_CLK     = w_mig_clk;
  assign w_o_rst_n = w_mig_rst_n;
  assign w_o_busy  = (state != S_IDLE);

  // Upper address bits fall off here, which is what makes addresses wrap.
  assign word_addr   = w_i_addr[AW-1:2];
  assign line_base   = word_addr & ~WAW'(LINE_WORDS - 1);
  assign done        = (cnt == 8'd1);
  assign unused_bits = ^{w_i_addr[1:0], w_i_addr >> AW};

  always_ff @(posedge w_mig_clk or negedge w_mig_rst_n) begin
    if (!w_mig_rst_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      rd_base    <= '0;
      wr_idx     <= '0;
      wr_data    <= 32'd0;
      wr_mask    <= 4'd0;
      w_o_data   <= '0;
      w_o_rvalid <= 1'b0;
    end else begin
      w_o_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (w_i_rd_en) begin
            rd_base <= line_base;
            cnt     <= 8'(RD_LAT);
            state   <= S_RD_WAIT;
          end else if (w_i_wr_en) begin
            wr_idx  <= word_addr;
            wr_data <= w_i_data;
            wr_mask <= w_i_mask;
            cnt     <= 8'(WR_LAT);
            state   <= S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          cnt <= cnt - 8'd1;
          if (done) begin
            state      <= S_IDLE;
            w_o_rvalid <= 1'b1;
            for (int i = 0; i < LINE_WORDS; i++)
              w_o_data[32*i +: 32] <= mem[rd_base | WAW'(i)];
          end
        end
        S_WR_WAIT: begin
          cnt <= cnt - 8'd1;
          if (done)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately never reset; a reset only cancels the pending write via state.
  always_ff @(posedge w_mig_clk) begin
    if (state == S_WR_WAIT && done) begin
      for (int b = 0; b < 4; b++)
        if (!wr_mask[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

`ifdef DRAM_SIM_CHECK_EN
  logic err_q;
  logic req;
  logic addr_hi;

  assign req     = w_i_rd_en | w_i_wr_en;
  assign addr_hi = ((w_i_addr >> AW) != 32'd0);

  always_ff @(posedge w_mig_clk or negedge w_mig_rst_n) begin
    if (!w_mig_rst_n) begin
      err_q <= 1'b0;
    end else begin
      if (req && w_o_busy) begin
        err_q <= 1'b1;
        $display("dram_sim_lat: request while busy at %0t", $time);
      end
      if (w_i_rd_en && w_i_wr_en) begin
        err_q <= 1'b1;
        $display("dram_sim_lat: rd_en and wr_en together at %0t", $time);
      end
      if (req && addr_hi) begin
        err_q <= 1'b1;
        $display("dram_sim_lat: address beyond array at %0t", $time);
      end
    end
  end

  assign w_o_err = err_q;
`else
  assign w_o_err = 1'b0;
`endif

endmodule
